// File: rtl/pipe_pkg.sv
// Shared definitions for the issue stage of the 4-stage register/ALU/memory
// pipeline: instruction field positions, ALU opcode values and the
// operand-use helpers that the RAW interlock relies on.
package pipe_pkg;

  localparam int INSTR_W = 24;

  // Field positions inside the packed 24-bit instruction word.
  localparam int FUNC_HI = 23;
  localparam int FUNC_LO = 20;
  localparam int RD_HI   = 19;
  localparam int RD_LO   = 16;
  localparam int RS1_HI  = 15;
  localparam int RS1_LO  = 12;
  localparam int RS2_HI  = 11;
  localparam int RS2_LO  = 8;
  localparam int ADDR_HI = 7;
  localparam int ADDR_LO = 0;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic [3:0] func;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] addr;
  } instr_t;

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_NOT  = 4'd3,
    FN_MOVB = 4'd4,
    FN_OR   = 4'd5,
    FN_XOR  = 4'd6,
    FN_ST   = 4'd7,
    FN_LD   = 4'd8,
    FN_NEGB = 4'd9,
    FN_INC  = 4'd10,
    FN_SHL  = 4'd11
  } func_e;

  localparam logic [3:0] FN_LAST_LEGAL = 4'd11;

  function automatic logic is_illegal(input logic [3:0] func);
    return func > FN_LAST_LEGAL;
  endfunction

  // Opcodes 4 and 9 take only the B operand; every other legal opcode reads rs1.
  function automatic logic uses_rs1(input logic [3:0] func);
    logic res;
    res = 1'b0;
    if (!is_illegal(func) && func != FN_MOVB && func != FN_NEGB) res = 1'b1;
    return res;
  endfunction

  // Opcodes 3, 8, 10 and 11 take only the A operand.
  function automatic logic uses_rs2(input logic [3:0] func);
    logic res;
    res = 1'b0;
    case (func)
      FN_ADD, FN_SUB, FN_AND, FN_MOVB, FN_OR, FN_XOR, FN_ST, FN_NEGB: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_sync_fifo.sv
// Single-clock instruction buffer for the issue stage.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write request and word (ignored when full)
//   pop             remove the head word (ignored when empty)
//   full, empty     occupancy flags
//   head            word at the read pointer (meaningless when empty)
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate occupancy counter.
module pipe_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pipe_issue_stage.sv
// Front stage of the 4-stage register/ALU/memory pipeline. Buffers packed
// instruction words, decodes one per clock into register/func/addr fields,
// interlocks on RAW hazards against recently issued destinations and drops
// words with illegal opcodes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_instr    incoming instruction word {func,rd,rs1,rs2,addr}
//   in_ready              buffer can accept a word (buffer not full)
//   issue_valid           fields carry a real instruction this cycle
//   rs1, rs2, rd, func    decoded register specifiers and ALU opcode
//   addr                  memory word address
//   illegal_err           one-cycle pulse when an illegal word is dropped
//   issue_cnt, bubble_cnt saturating counts of issues and hazard bubbles
module pipe_issue_stage
  import pipe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_WINDOW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                in_ready,
  output logic                issue_valid,
  output logic [3:0]          rs1,
  output logic [3:0]          rs2,
  output logic [3:0]          rd,
  output logic [3:0]          func,
  output logic [7:0]          addr,
  output logic                illegal_err,
  output logic [15:0]         issue_cnt,
  output logic [15:0]         bubble_cnt
);

  // A producer's writeback lands on the HAZ_WINDOW-th edge after it issues,
  // so a consumer may issue on that very edge. Only the HAZ_WINDOW-1 slots in
  // between need tracking; a window of 1 therefore never interlocks.
  localparam int  SB_DEPTH = (HAZ_WINDOW > 1) ? HAZ_WINDOW - 1 : 1;
  localparam bit  SB_EN    = (HAZ_WINDOW > 1);

  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               fifo_pop;
  instr_t             head_instr;

  logic [SB_DEPTH-1:0] sb_valid;
  logic [3:0]          sb_rd [SB_DEPTH];

  logic head_illegal;
  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  logic do_issue;
  logic do_drop;

  logic [15:0] issue_cnt_q;
  logic [15:0] bubble_cnt_q;

  assign in_ready = !fifo_full;

  pipe_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_instr),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign head_instr   = instr_t'(fifo_head);
  assign head_illegal = is_illegal(head_instr.func);

  // RAW check of the head's used sources against in-flight destinations.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (SB_EN && sb_valid[i] && sb_rd[i] == head_instr.rs1) rs1_hit = 1'b1;
      if (SB_EN && sb_valid[i] && sb_rd[i] == head_instr.rs2) rs2_hit = 1'b1;
    end
  end

  assign hazard   = !fifo_empty && !head_illegal &&
                    ((uses_rs1(head_instr.func) && rs1_hit) ||
                     (uses_rs2(head_instr.func) && rs2_hit));
  assign do_issue = !fifo_empty && !head_illegal && !hazard;
  assign do_drop  = !fifo_empty && head_illegal;
  assign fifo_pop = do_issue || do_drop;

  // Bubbles and dropped words shift in as invalid so they never interlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      for (int i = SB_DEPTH - 1; i > 0; i--) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
      sb_valid[0] <= do_issue;
      sb_rd[0]    <= head_instr.rd;
    end
  end

  // Fields only change on a real issue; downstream qualifies on issue_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      illegal_err <= 1'b0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      func        <= '0;
      addr        <= '0;
    end else begin
      issue_valid <= do_issue;
      illegal_err <= do_drop;
      if (do_issue) begin
        rs1  <= head_instr.rs1;
        rs2  <= head_instr.rs2;
        rd   <= head_instr.rd;
        func <= head_instr.func;
        addr <= head_instr.addr;
      end
    end
  end

  // Illegal drops are not hazard bubbles and are excluded from bubble_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (do_issue && issue_cnt_q != 16'hFFFF) issue_cnt_q <= issue_cnt_q + 16'd1;
      if (hazard && bubble_cnt_q != 16'hFFFF)  bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_issue_stage.sv
// Self-checking bench for pipe_issue_stage. Stimulus pushes the expected
// decoded word into a queue; a negedge monitor pops and compares whenever
// issue_valid is seen, and records issue times and illegal pulses.
module tb_pipe_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_instr;
  logic        in_ready;
  logic        issue_valid;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic [3:0]  func;
  logic [7:0]  addr;
  logic        illegal_err;
  logic [15:0] issue_cnt;
  logic [15:0] bubble_cnt;

  int total;
  int bad;
  int cyc;
  int illegal_seen;
  logic [23:0] exp_q[$];
  int          issue_times[$];

  pipe_issue_stage #(
    .FIFO_DEPTH (4),
    .HAZ_WINDOW (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .issue_valid (issue_valid),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .illegal_err (illegal_err),
    .issue_cnt   (issue_cnt),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int a);
    logic [23:0] w;
    w = {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
    return w;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every issue must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && issue_valid) begin
      issue_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_output("unexpected_issue", 32'({func, rd, rs1, rs2, addr}), 32'hFFFFFFFF);
      end else begin
        check_output("issue_fields", 32'({func, rd, rs1, rs2, addr}), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && illegal_err) illegal_seen++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one word; waits (bounded) while the buffer is full.
  task automatic apply_stimulus(input logic [23:0] w, input bit expect_issue);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_instr = w;
    if (expect_issue) exp_q.push_back(w);
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check_output("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 24'hABCDEF;
  endtask

  task automatic clear_model();
    exp_q.delete();
    issue_times.delete();
    illegal_seen = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    illegal_seen = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = 24'h0;

    // Reset state
    #12;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_output("rst_illegal_err", 32'(illegal_err), 32'd0);
    check_output("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check_output("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check_output("rst_fields", 32'({func, rd, rs1, rs2, addr}), 32'd0);
    do_reset();

    // Independent stream of 6 words, back to back
    $display("[TB] independent stream");
    apply_stimulus(mk(0, 8, 0, 1, 8'h10), 1'b1);
    apply_stimulus(mk(1, 9, 1, 2, 8'h11), 1'b1);
    apply_stimulus(mk(2, 10, 2, 3, 8'h12), 1'b1);
    apply_stimulus(mk(5, 11, 3, 4, 8'h13), 1'b1);
    apply_stimulus(mk(6, 12, 4, 5, 8'h14), 1'b1);
    apply_stimulus(mk(7, 13, 5, 6, 8'h15), 1'b1);
    wait_cycles(6);
    check_output("indep_issue_cnt", 32'(issue_cnt), 32'd6);
    check_output("indep_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check_output("indep_issue_count", 32'(issue_times.size()), 32'd6);
    if (issue_times.size() == 6)
      check_output("indep_consecutive", 32'(issue_times[5] - issue_times[0]), 32'd5);
    check_drained("indep_drained");
    do_reset();

    // RAW: ADD r3=r1+r2 then SUB r4=r3-r5
    $display("[TB] raw hazard");
    apply_stimulus(mk(0, 3, 1, 2, 8'h20), 1'b1);
    apply_stimulus(mk(1, 4, 3, 5, 8'h21), 1'b1);
    wait_cycles(8);
    check_output("raw_bubble_cnt", 32'(bubble_cnt), 32'd2);
    check_output("raw_issue_cnt", 32'(issue_cnt), 32'd2);
    check_output("raw_issue_count", 32'(issue_times.size()), 32'd2);
    if (issue_times.size() == 2)
      check_output("raw_gap", 32'(issue_times[1] - issue_times[0]), 32'd3);
    check_drained("raw_drained");
    do_reset();

    // Same pair but consumer reads only rs2 (func 4): no interlock
    $display("[TB] rs2-only consumer");
    apply_stimulus(mk(0, 3, 1, 2, 8'h30), 1'b1);
    apply_stimulus(mk(4, 4, 3, 5, 8'h31), 1'b1);
    wait_cycles(6);
    check_output("rs2only_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check_output("rs2only_issue_count", 32'(issue_times.size()), 32'd2);
    if (issue_times.size() == 2)
      check_output("rs2only_gap", 32'(issue_times[1] - issue_times[0]), 32'd1);
    check_drained("rs2only_drained");
    do_reset();

    // Illegal func 13 between two legal words
    $display("[TB] illegal drop");
    apply_stimulus(mk(0, 8, 1, 2, 8'h40), 1'b1);
    apply_stimulus(mk(13, 9, 1, 2, 8'h41), 1'b0);
    apply_stimulus(mk(1, 10, 3, 4, 8'h42), 1'b1);
    wait_cycles(6);
    check_output("illegal_pulses", 32'(illegal_seen), 32'd1);
    check_output("illegal_issue_cnt", 32'(issue_cnt), 32'd2);
    check_output("illegal_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check_output("illegal_issue_count", 32'(issue_times.size()), 32'd2);
    if (issue_times.size() == 2)
      check_output("illegal_gap", 32'(issue_times[1] - issue_times[0]), 32'd2);
    check_drained("illegal_drained");
    do_reset();

    // Full buffer: dependent chain stalls issue, 7th word waits for space
    $display("[TB] full buffer");
    apply_stimulus(mk(0, 3, 1, 2, 8'h50), 1'b1);
    apply_stimulus(mk(1, 4, 3, 5, 8'h51), 1'b1);
    apply_stimulus(mk(3, 5, 4, 0, 8'h52), 1'b1);
    apply_stimulus(mk(3, 6, 5, 0, 8'h53), 1'b1);
    apply_stimulus(mk(3, 7, 6, 0, 8'h54), 1'b1);
    apply_stimulus(mk(3, 8, 7, 0, 8'h55), 1'b1);
    check_output("full_in_ready", 32'(in_ready), 32'd0);
    apply_stimulus(mk(3, 9, 8, 0, 8'h56), 1'b1);
    wait_cycles(20);
    check_output("full_issue_cnt", 32'(issue_cnt), 32'd7);
    check_output("full_bubble_cnt", 32'(bubble_cnt), 32'd12);
    check_drained("full_drained");
    do_reset();

    // Reset asserted with 3 words buffered
    $display("[TB] mid-stream reset");
    apply_stimulus(mk(0, 3, 1, 2, 8'h60), 1'b1);
    apply_stimulus(mk(1, 4, 3, 5, 8'h61), 1'b0);
    apply_stimulus(mk(3, 5, 4, 0, 8'h62), 1'b0);
    apply_stimulus(mk(3, 6, 5, 0, 8'h63), 1'b0);
    check_output("pre_rst_issue_cnt", 32'(issue_cnt), 32'd1);
    rst_n = 1'b0;
    clear_model();
    #2;
    check_output("async_rst_in_ready", 32'(in_ready), 32'd1);
    check_output("async_rst_issue_valid", 32'(issue_valid), 32'd0);
    check_output("async_rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check_output("async_rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(8);
    check_output("post_rst_idle_cnt", 32'(issue_cnt), 32'd0);
    check_output("post_rst_idle_issues", 32'(issue_times.size()), 32'd0);
    apply_stimulus(mk(2, 7, 1, 2, 8'h64), 1'b1);
    wait_cycles(3);
    check_output("post_rst_issue_cnt", 32'(issue_cnt), 32'd1);
    check_drained("post_rst_drained");
    do_reset();

    // Saturation of issue_cnt
    $display("[TB] counter saturation");
    @(negedge clk);
    force dut.issue_cnt_q = 16'hFFFE;
    #1;
    release dut.issue_cnt_q;
    apply_stimulus(mk(0, 8, 1, 2, 8'h70), 1'b1);
    apply_stimulus(mk(1, 9, 3, 4, 8'h71), 1'b1);
    apply_stimulus(mk(2, 10, 5, 6, 8'h72), 1'b1);
    wait_cycles(4);
    check_output("sat_issue_cnt", 32'(issue_cnt), 32'h0000FFFF);
    check_output("sat_bubble_cnt", 32'(bubble_cnt), 32'd0);
    check_drained("sat_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
